// File: rtl/data_memory_responder.sv
// data_memory_responder: single-port byte-addressable RV32I data memory that
// answers each load/store with a fixed, parameterised latency and a
// valid/ready response handshake. Misaligned, out-of-range or illegal-width
// requests complete with an error and leave memory untouched.
`timescale 1ns/1ps
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_count;
    logic [3:0]    w_count_next;
    logic          w_commit;

    // Captured request
    logic          r_write;
    logic [2:0]    r_func3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    // Registered response
    logic [31:0]   r_rdata;
    logic          r_err;

    // Storage: no reset, contents persist across reset
    logic [31:0]   r_mem [DEPTH_WORDS];

    // Operation being committed: with LATENCY=1 the commit edge is the accept
    // edge itself, so the live request is used instead of the captured copy.
    logic          w_op_write;
    logic [2:0]    w_op_func3;
    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wdata;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic          w_err;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [31:0]   w_merged;

    assign req_ready      = (r_state == ST_IDLE);
    assign resp_valid     = (r_state == ST_RESP);
    assign resp_read_data = r_rdata;
    assign resp_error     = r_err;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, latency counter and commit strobe
    always_comb begin
        w_next_state = r_state;
        w_count_next = r_count;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = ST_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_count_next = LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_count == 4'd1) begin
                    w_next_state = ST_RESP;
                    w_commit     = 1'b1;
                    w_count_next = 4'd0;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_count_next = 4'd0;
            end
        endcase
    end

    // Operand selection, error decode, load extraction and store merge
    always_comb begin
        w_op_write = r_write;
        w_op_func3 = r_func3;
        w_op_addr  = r_addr;
        w_op_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_op_write = req_write;
            w_op_func3 = req_func3;
            w_op_addr  = req_address;
            w_op_wdata = req_write_data;
        end

        w_idx  = w_op_addr[AW+1:2];
        w_word = r_mem[w_idx];

        w_err = 1'b0;
        if (|w_op_addr[31:AW+2]) begin
            w_err = 1'b1;
        end
        if ((w_op_func3[1:0] == 2'b01) && w_op_addr[0]) begin
            w_err = 1'b1;
        end
        if ((w_op_func3[1:0] == 2'b10) && (w_op_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
        if (w_op_write) begin
            if (w_op_func3 > 3'd2) begin
                w_err = 1'b1;
            end
        end else if ((w_op_func3 == 3'd3) || (w_op_func3 == 3'd6) || (w_op_func3 == 3'd7)) begin
            w_err = 1'b1;
        end

        case (w_op_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_op_addr[1] ? w_word[31:16] : w_word[15:0];

        case (w_op_func3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd2:    w_load = w_word;
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = '0;
        endcase

        w_merged = w_word;
        case (w_op_func3[1:0])
            2'd0: begin
                case (w_op_addr[1:0])
                    2'd0:    w_merged[7:0]   = w_op_wdata[7:0];
                    2'd1:    w_merged[15:8]  = w_op_wdata[7:0];
                    2'd2:    w_merged[23:16] = w_op_wdata[7:0];
                    default: w_merged[31:24] = w_op_wdata[7:0];
                endcase
            end
            2'd1: begin
                if (w_op_addr[1]) begin
                    w_merged[31:16] = w_op_wdata[15:0];
                end else begin
                    w_merged[15:0]  = w_op_wdata[15:0];
                end
            end
            default: w_merged = w_op_wdata;
        endcase
    end

    // Request capture, latency counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_write <= 1'b0;
            r_func3 <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (req_valid && (r_state == ST_IDLE)) begin
                r_write <= req_write;
                r_func3 <= req_func3;
                r_addr  <= req_address;
                r_wdata <= req_write_data;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_op_write) ? '0 : w_load;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    // Store commit on the edge entering RESP; errored requests never write
    always_ff @(posedge clk) begin
        if (w_commit && w_op_write && !w_err && !reset) begin
            r_mem[w_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: three responders (LATENCY 2, 3, 1) on a shared clock/reset.
`timescale 1ns/1ps
module tb_data_memory_responder;

    logic        clk;
    logic        reset;
    logic        req_valid      [3];
    logic        req_ready      [3];
    logic        req_write      [3];
    logic [2:0]  req_func3      [3];
    logic [31:0] req_address    [3];
    logic [31:0] req_write_data [3];
    logic        resp_valid     [3];
    logic        resp_ready     [3];
    logic [31:0] resp_read_data [3];
    logic        resp_error     [3];

    int total;
    int bad;
    logic [31:0] rd;
    logic        er;
    int          lat;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_responder #(
            .DEPTH_WORDS(256),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 3 : 1))
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_write     (req_write[g]),
            .req_func3     (req_func3[g]),
            .req_address   (req_address[g]),
            .req_write_data(req_write_data[g]),
            .resp_valid    (resp_valid[g]),
            .resp_ready    (resp_ready[g]),
            .resp_read_data(resp_read_data[g]),
            .resp_error    (resp_error[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction with resp_ready held high; lat counts edges from accept to resp_valid
    task automatic do_txn(input int d, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] o_rd, output logic o_er, output int o_lat);
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_func3[d] = f3;
        req_address[d] = a; req_write_data[d] = wd; resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        o_lat = 1;
        @(negedge clk);
        while (resp_valid[d] !== 1'b1 && o_lat < 40) begin
            @(negedge clk);
            o_lat++;
        end
        o_rd = resp_read_data[d];
        o_er = resp_error[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 3; d++) begin
            total++; if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_req_ready[%0d] got=%b want=1", d, req_ready[d]); end
            total++; if (resp_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_resp_valid[%0d] got=%b want=0", d, resp_valid[d]); end
            total++; if (resp_read_data[d] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h want=0", d, resp_read_data[d]); end
            total++; if (resp_error[d] !== 1'b0) begin bad++; $display("FAIL reset_error[%0d] got=%b want=0", d, resp_error[d]); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word();
        do_txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL sw10_latency got=%0d want=2", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sw10_error got=%b want=0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw10_data got=%h want=0", rd); end
        do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL lw10_latency got=%0d want=2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw10_data got=%h want=deadbeef", rd); end
        do_txn(0, 1'b1, 3'd2, 32'h3FC, 32'h89ABCDEF, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sw3fc_error got=%b want=0", er); end
        do_txn(0, 1'b0, 3'd2, 32'h3FC, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h89ABCDEF) begin bad++; $display("FAIL lw3fc_data got=%h want=89abcdef", rd); end
    endtask

    task automatic test_subword();
        do_txn(0, 1'b1, 3'd0, 32'h11, 32'h00000080, rd, er, lat);
        total++; if ({er, rd} !== 33'h0) begin bad++; $display("FAIL sb11_resp got=%b/%h want=0/0", er, rd); end
        do_txn(0, 1'b0, 3'd0, 32'h11, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb11_data got=%h want=ffffff80", rd); end
        do_txn(0, 1'b0, 3'd4, 32'h11, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu11_data got=%h want=00000080", rd); end
        do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD80EF) begin bad++; $display("FAIL lw10_after_sb got=%h want=dead80ef", rd); end
        do_txn(0, 1'b1, 3'd2, 32'h14, 32'h11223344, rd, er, lat);
        do_txn(0, 1'b1, 3'd1, 32'h16, 32'hABCD8001, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sh16_error got=%b want=0", er); end
        do_txn(0, 1'b0, 3'd2, 32'h14, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h80013344) begin bad++; $display("FAIL lw14_after_sh got=%h want=80013344", rd); end
        do_txn(0, 1'b0, 3'd1, 32'h16, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh16_data got=%h want=ffff8001", rd); end
        do_txn(0, 1'b0, 3'd5, 32'h16, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu16_data got=%h want=00008001", rd); end
        do_txn(0, 1'b0, 3'd0, 32'h14, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00000044) begin bad++; $display("FAIL lb14_data got=%h want=00000044", rd); end
    endtask

    task automatic test_errors();
        do_txn(0, 1'b0, 3'd1, 32'h13, 32'h0, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL lh13_err got=%b/%h want=1/0", er, rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL lh13_latency got=%0d want=2", lat); end
        do_txn(0, 1'b1, 3'd2, 32'h0, 32'hCAFEF00D, rd, er, lat);
        do_txn(0, 1'b1, 3'd2, 32'h402, 32'h11111111, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL sw402_err got=%b/%h want=1/0", er, rd); end
        do_txn(0, 1'b1, 3'd2, 32'h400, 32'h22222222, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sw400_err got=%b want=1", er); end
        do_txn(0, 1'b1, 3'd4, 32'h0, 32'h33333333, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL store_f3_4_err got=%b want=1", er); end
        do_txn(0, 1'b1, 3'd1, 32'h1, 32'h44444444, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sh1_err got=%b want=1", er); end
        do_txn(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin bad++; $display("FAIL lw0_unchanged got=%b/%h want=0/cafef00d", er, rd); end
        do_txn(0, 1'b0, 3'd3, 32'h0, 32'h0, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL load_f3_3_err got=%b/%h want=1/0", er, rd); end
        do_txn(0, 1'b0, 3'd6, 32'h0, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL load_f3_6_err got=%b want=1", er); end
        do_txn(0, 1'b0, 3'd2, 32'h12, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL lw12_err got=%b want=1", er); end
    endtask

    task automatic test_backpressure();
        int n;
        do_txn(0, 1'b1, 3'd2, 32'h30, 32'h5555AAAA, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_func3[0] = 3'd2;
        req_address[0] = 32'h30; resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (resp_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++; if (n >= 40) begin bad++; $display("FAIL bp_wait_resp got=timeout want=resp_valid"); end
        for (int i = 0; i < 5; i++) begin
            total++; if (resp_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, resp_valid[0]); end
            total++; if (resp_read_data[0] !== 32'h5555AAAA) begin bad++; $display("FAIL bp_data[%0d] got=%h want=5555aaaa", i, resp_read_data[0]); end
            total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b want=0", i, req_ready[0]); end
            req_valid[0] = 1'b1; req_write[0] = 1'b1; req_func3[0] = 3'd2;
            req_address[0] = 32'h30; req_write_data[0] = 32'h0;
            @(negedge clk);
            req_valid[0] = 1'b0;
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_idle_after got=%b want=1", req_ready[0]); end
        do_txn(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h5555AAAA) begin bad++; $display("FAIL bp_no_accept got=%h want=5555aaaa", rd); end
    endtask

    task automatic test_reset_abort();
        int n;
        do_txn(1, 1'b1, 3'd2, 32'h20, 32'h0BADF00D, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL lat3_latency got=%0d want=3", lat); end
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_func3[1] = 3'd2;
        req_address[1] = 32'h20; req_write_data[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if ({req_ready[1], resp_valid[1], resp_error[1]} !== 3'b100) begin bad++; $display("FAIL abort_flags got=%b want=100", {req_ready[1], resp_valid[1], resp_error[1]}); end
        total++; if (resp_read_data[1] !== 32'h0) begin bad++; $display("FAIL abort_data got=%h want=0", resp_read_data[1]); end
        @(negedge clk);
        reset = 1'b0;
        do_txn(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL abort_no_write got=%h want=0badf00d", rd); end
        // Reset while holding a committed store's response
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_func3[1] = 3'd2;
        req_address[1] = 32'h24; req_write_data[1] = 32'h77777777; resp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (resp_valid[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++; if (n >= 40) begin bad++; $display("FAIL resp_reset_wait got=timeout want=resp_valid"); end
        reset = 1'b1;
        #1;
        total++; if (resp_valid[1] !== 1'b0) begin bad++; $display("FAIL resp_reset_valid got=%b want=0", resp_valid[1]); end
        @(negedge clk);
        reset = 1'b0;
        resp_ready[1] = 1'b1;
        do_txn(1, 1'b0, 3'd2, 32'h24, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h77777777) begin bad++; $display("FAIL resp_reset_persist got=%h want=77777777", rd); end
    endtask

    task automatic test_back_to_back();
        int hits;
        do_txn(2, 1'b1, 3'd2, 32'h8, 32'h01020304, rd, er, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL lat1_sw_latency got=%0d want=1", lat); end
        do_txn(2, 1'b0, 3'd2, 32'h8, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL lat1_lw_data got=%h want=01020304", rd); end
        do_txn(2, 1'b0, 3'd1, 32'h9, 32'h0, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL lat1_lh9_err got=%b/%h want=1/0", er, rd); end
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_func3[2] = 3'd2;
        req_address[2] = 32'h40; req_write_data[2] = 32'hA5A5A5A5; resp_ready[2] = 1'b1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            total++; if (req_ready[2] !== ((i % 2) == 0)) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", i, req_ready[2], ((i % 2) == 0)); end
            if (resp_valid[2] === 1'b1) hits++;
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        total++; if (hits !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", hits); end
        do_txn(2, 1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL b2b_lw40 got=%h want=a5a5a5a5", rd); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_func3[d] = '0;
            req_address[d] = '0; req_write_data[d] = '0; resp_ready[d] = 1'b1;
        end
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
